// File: rtl/aes_tur_denetleyici.sv
// Iterative AES-128 round sequencer: owns the cipher state, performs the key additions
// and steps an external combinational round function once per fetched round key.
module aes_tur_denetleyici #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         baslat_i,
    input  logic         iptal_i,
    input  logic [127:0] duz_metin_i,
    output logic         hazir_o,
    output logic [3:0]   tur_no_o,
    output logic         anahtar_istek_o,
    input  logic         anahtar_gecerli_i,
    input  logic [127:0] tur_anahtari_i,
    output logic [127:0] tur_girdi_o,
    output logic         son_tur_o,
    input  logic [127:0] tur_cikti_i,
    output logic [127:0] sifreli_metin_o,
    output logic         bitti_o
);

    // state          | meaning
    // BOS            | idle, plaintext captured on baslat
    // ANAHTAR_BEKLE  | waiting for the key of round tur_no, applies it on anahtar_gecerli
    // BITTI          | one-cycle done pulse, ciphertext valid
    typedef enum logic [1:0] {
        BOS           = 2'd0,
        ANAHTAR_BEKLE = 2'd1,
        BITTI         = 2'd2
    } durum_e;

    localparam logic [3:0] NR_L = 4'(NR);

    durum_e       state_q, state_d;
    logic [127:0] durum_q, durum_d;
    logic [3:0]   tur_no_q, tur_no_d;
    logic         son_tur;

    assign son_tur = (tur_no_q == NR_L);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= BOS;
            durum_q  <= '0;
            tur_no_q <= '0;
        end else begin
            state_q  <= state_d;
            durum_q  <= durum_d;
            tur_no_q <= tur_no_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        durum_d  = durum_q;
        tur_no_d = tur_no_q;
        // Abort leaves durum intact so the last ciphertext stays readable.
        if (iptal_i) begin
            state_d  = BOS;
            tur_no_d = '0;
        end else begin
            case (state_q)
                BOS: begin
                    if (baslat_i) begin
                        durum_d  = duz_metin_i;
                        tur_no_d = '0;
                        state_d  = ANAHTAR_BEKLE;
                    end
                end
                ANAHTAR_BEKLE: begin
                    if (anahtar_gecerli_i) begin
                        // Round 0 is the bare initial AddRoundKey.
                        if (tur_no_q == 4'd0) begin
                            durum_d = durum_q ^ tur_anahtari_i;
                        end else begin
                            durum_d = tur_cikti_i ^ tur_anahtari_i;
                        end
                        if (son_tur) begin
                            state_d = BITTI;
                        end else begin
                            tur_no_d = tur_no_q + 4'd1;
                        end
                    end
                end
                BITTI: begin
                    state_d = BOS;
                end
                default: begin
                    state_d = BOS;
                end
            endcase
        end
    end

    assign hazir_o         = (state_q == BOS);
    assign anahtar_istek_o = (state_q == ANAHTAR_BEKLE);
    assign bitti_o         = (state_q == BITTI);
    assign son_tur_o       = (state_q == ANAHTAR_BEKLE) && son_tur;
    assign tur_no_o        = tur_no_q;
    assign tur_girdi_o     = durum_q;
    assign sifreli_metin_o = durum_q;

endmodule

// File: tb/tb_aes_tur_denetleyici.sv
// Bench for aes_tur_denetleyici: models key expansion and the AES round function,
// checks ciphertext and done timing through a scoreboard plus directed corner cases.
module tb_aes_tur_denetleyici;

    localparam int NR = 10;

    logic         clk, rst, baslat, iptal, gecerli;
    logic [127:0] duz, tur_anahtari, tur_cikti;
    logic         hazir, anahtar_istek, son_tur, bitti;
    logic [3:0]   tur_no;
    logic [127:0] tur_girdi, sifreli;

    aes_tur_denetleyici #(.NR(NR)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .baslat_i         (baslat),
        .iptal_i          (iptal),
        .duz_metin_i      (duz),
        .hazir_o          (hazir),
        .tur_no_o         (tur_no),
        .anahtar_istek_o  (anahtar_istek),
        .anahtar_gecerli_i(gecerli),
        .tur_anahtari_i   (tur_anahtari),
        .tur_girdi_o      (tur_girdi),
        .son_tur_o        (son_tur),
        .tur_cikti_i      (tur_cikti),
        .sifreli_metin_o  (sifreli),
        .bitti_o          (bitti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- AES reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // S-box from first principles: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gm(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    logic [127:0] rk [0:10];

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] st;
        st = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) st = round_fn(st, r == NR) ^ rk[r];
        return st;
    endfunction

    // External key-expansion block and round function seen by the DUT
    always_comb tur_anahtari = (tur_no <= 4'd10) ? rk[tur_no] : '0;
    always_comb tur_cikti    = round_fn(tur_girdi, son_tur);

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] ct;
        int           when;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (bitti) begin
            if (sbq.size() == 0) begin
                chk("unexpected_bitti", 128'(bitti), 128'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("ciphertext", sifreli, e.ct);
                chk("bitti_cycle", 128'(cyc), 128'(e.when));
            end
        end
    end

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ark;
        logic [127:0] ct;
        int           stall_at;
        int           stall_len;
        int           busy_at;
    } vec_t;
    vec_t vt [6];

    // Caller is just past a negedge with the DUT in BOS; returns the same way.
    task automatic run_enc(input vec_t v);
        int  exp_tn, stalls;
        bit  done, ark_done, was_stall;
        logic [127:0] hold;
        expand(v.key);
        chk("hazir_before_start", 128'(hazir), 128'd1);
        duz = v.pt; baslat = 1'b1; gecerli = 1'b1;
        sbq.push_back('{ct: v.ct, when: cyc + NR + 2 + v.stall_len});
        exp_tn = 0; stalls = 0; done = 0; ark_done = 0; was_stall = 0; hold = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            baslat = 1'b0;
            duz = ~v.pt;
            if (was_stall) begin
                chk("stall_hold_state", tur_girdi, hold);
                was_stall = 0;
            end
            if (exp_tn == NR && gecerli && tur_no == 4'(NR) && !anahtar_istek) begin
                done = 1;
                chk("hazir_in_bitti", 128'(hazir), 128'd0);
            end else begin
                chk("tur_no", 128'(tur_no), 128'(exp_tn));
                chk("son_tur", 128'(son_tur), 128'(exp_tn == NR));
                chk("anahtar_istek", 128'(anahtar_istek), 128'd1);
                chk("hazir_busy", 128'(hazir), 128'd0);
                if (exp_tn == 1 && !ark_done) begin
                    chk("initial_addroundkey", tur_girdi, v.ark);
                    ark_done = 1;
                end
                if (exp_tn == v.busy_at && c < 30) begin
                    baslat = 1'b1;
                    v.busy_at = -1;
                end
                if (exp_tn == v.stall_at && stalls < v.stall_len) begin
                    gecerli = 1'b0;
                    stalls++;
                    hold = tur_girdi;
                    was_stall = 1;
                end else begin
                    gecerli = 1'b1;
                    if (exp_tn < NR) exp_tn++;
                end
            end
        end
        if (!done) chk("enc_timeout", 128'(done), 128'd1);
        @(negedge clk);
        baslat = 1'b0;
        chk("hazir_after", 128'(hazir), 128'd1);
        chk("bitti_one_cycle", 128'(bitti), 128'd0);
        chk("ct_hold", sifreli, v.ct);
    endtask

    task automatic start_plain(input logic [127:0] pt);
        duz = pt; baslat = 1'b1; gecerli = 1'b1;
        @(negedge clk);
        baslat = 1'b0;
    endtask

    task automatic wait_tn(input logic [3:0] tn);
        for (int c = 0; c < 40 && tur_no != tn; c++) @(negedge clk);
        chk("reach_tur_no", 128'(tur_no), 128'(tn));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] hold;
        rst = 1'b1; baslat = 1'b0; iptal = 1'b0; gecerli = 1'b0; duz = '0;

        vt[0] = '{pt: 128'h54776F204F6E65204E696E652054776F, key: 128'h5468617473206D79204B756E67204675,
                  ark: 128'h001F0E543C4E08596E221B0B4774311A, ct: 128'h29C3505F571420F6402299B31A02D73A,
                  stall_at: -1, stall_len: 0, busy_at: -1};
        vt[1] = vt[0]; vt[1].stall_at = 4; vt[1].stall_len = 3;
        vt[2] = vt[0]; vt[2].busy_at = 3;
        vt[3] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                  ark: 128'h00102030405060708090a0b0c0d0e0f0, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  stall_at: -1, stall_len: 0, busy_at: -1};
        for (int i = 4; i < 6; i++) begin
            vt[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vt[i].key = {$urandom, $urandom, $urandom, $urandom};
            vt[i].ark = vt[i].pt ^ vt[i].key;
            expand(vt[i].key);
            vt[i].ct = aes_ref(vt[i].pt);
            vt[i].busy_at = -1;
        end
        vt[4].stall_at = NR; vt[4].stall_len = 2;
        vt[5].stall_at = 0;  vt[5].stall_len = 1;
        expand(vt[0].key);

        #12;
        chk("rst_hazir", 128'(hazir), 128'd1);
        chk("rst_istek", 128'(anahtar_istek), 128'd0);
        chk("rst_bitti", 128'(bitti), 128'd0);
        chk("rst_son_tur", 128'(son_tur), 128'd0);
        chk("rst_tur_no", 128'(tur_no), 128'd0);
        chk("rst_ct", sifreli, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_enc(vt[i]);

        // Asynchronous reset in the middle of round 5
        expand(vt[0].key);
        start_plain(vt[0].pt);
        wait_tn(4'd5);
        #2 rst = 1'b1;
        #1;
        chk("midrst_hazir", 128'(hazir), 128'd1);
        chk("midrst_istek", 128'(anahtar_istek), 128'd0);
        chk("midrst_bitti", 128'(bitti), 128'd0);
        chk("midrst_tur_no", 128'(tur_no), 128'd0);
        chk("midrst_ct", sifreli, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Abort at round 6 with a simultaneous start request, then restart
        start_plain(vt[3].pt);
        wait_tn(4'd6);
        hold = tur_girdi;
        iptal = 1'b1; baslat = 1'b1;
        @(negedge clk);
        iptal = 1'b0; baslat = 1'b0;
        chk("abort_hazir", 128'(hazir), 128'd1);
        chk("abort_tur_no", 128'(tur_no), 128'd0);
        chk("abort_istek", 128'(anahtar_istek), 128'd0);
        chk("abort_state_kept", tur_girdi, hold);
        run_enc(vt[0]);

        repeat (3) @(negedge clk);
        chk("sb_empty", 128'(sbq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
